piano_key_highlighter: RTL and testbench

- Parametrised, clocked successor to the combinational keyboard renderer.
- Draws a chromatic keyboard starting on A for any key count.
- Accepts any number of voice slots and latches active notes into per-key hold counters, so highlights persist for a set number of video frames after release.
- Sits between the note/voice scheduler and the VGA colour mux; the pixel path is pipelined with fixed latency.

---
 rtl/piano_key_highlighter.sv | 174 +++++++++++++++++
 tb/tb_piano_key_highlighter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piano_key_highlighter.sv
// Clocked piano keyboard renderer: per-pixel key hit test in a 2-stage pipe,
// with per-key hold counters that keep released notes lit for a few frames.
module piano_key_highlighter #(
   parameter int NUM_VOICES  = 8,
   parameter int NUM_KEYS    = 64,
   parameter int NOTE_W      = 7,
   parameter int HOLD_FRAMES = 4,
   parameter int KEY_X0      = 10,
   parameter int WHITE_W     = 34,
   parameter int BLACK_W     = 24,
   parameter int Y_TOP       = 780,
   parameter int Y_SPLIT     = 920,
   parameter int Y_BOTTOM    = 1023
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [10:0]                      x,
   input  logic [9:0]                       y,
   input  logic                             de,
   input  logic                             frame_start,
   input  logic [NUM_VOICES*(NOTE_W+1)-1:0] voices,
   input  logic                             voices_valid,
   output logic                             white_key,
   output logic                             black_key,
   output logic                             play,
   output logic [NOTE_W-1:0]                key_index,
   output logic                             out_valid
);

   localparam int CW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
   localparam int SW = NOTE_W + 1;

   function automatic int nat_rank(input int off);
      case (off)
         2:       return 1;
         3:       return 2;
         5:       return 3;
         7:       return 4;
         8:       return 5;
         10:      return 6;
         default: return 0;
      endcase
   endfunction

   function automatic bit is_black(input int off);
      return (off == 1) || (off == 4) || (off == 6) ||
             (off == 9) || (off == 11);
   endfunction

   function automatic int wpos(input int k);
      if (k < 1) return 0;
      return ((k - 1) / 12) * 7 + nat_rank((k - 1) % 12);
   endfunction

   int xi, yi;
   assign xi = int'(x);
   assign yi = int'(y);

   logic [NUM_KEYS:1] in_span, blk_mask;

   // Each key's horizontal span is a constant window; a black key is
   // centred on the right edge of the natural just below it.
   for (genvar k = 1; k <= NUM_KEYS; k++) begin : g_key
      localparam int  OFF   = (k - 1) % 12;
      localparam bit  BLK   = is_black(OFF);
      localparam int  EDGE  = KEY_X0 + (wpos(k - 1) + 1) * WHITE_W;
      localparam int  LEFT  = BLK ? EDGE - BLACK_W / 2
                                  : KEY_X0 + wpos(k) * WHITE_W;
      localparam int  RIGHT = BLK ? LEFT + BLACK_W : LEFT + WHITE_W;
      assign blk_mask[k] = BLK;
      assign in_span[k]  = (xi > LEFT) && (xi < RIGHT);
   end

   logic [NUM_KEYS:1] lit, load, hit_b, hit_w;
   logic              top, bot;
   logic              wht1_d, blk1_d, ply1_d;
   logic [NOTE_W-1:0] idx1_d;

   always_comb begin
      top   = de && (yi >= Y_TOP) && (yi <= Y_SPLIT);
      bot   = de && (yi > Y_SPLIT) && (yi <= Y_BOTTOM);
      hit_b = '0;
      hit_w = '0;
      if (top) begin
         hit_b = in_span & blk_mask;
         hit_w = (|hit_b) ? '0 : (in_span & ~blk_mask);
      end else if (bot) begin
         hit_w = in_span & ~blk_mask;
      end
      idx1_d = '0;
      for (int k = 1; k <= NUM_KEYS; k++)
         if (hit_b[k] || hit_w[k]) idx1_d |= NOTE_W'(k);
      wht1_d = |hit_w;
      blk1_d = |hit_b;
      ply1_d = |((hit_b | hit_w) & lit);
   end

   always_comb begin
      load = '0;
      for (int v = 0; v < NUM_VOICES; v++)
         for (int k = 1; k <= NUM_KEYS; k++)
            if (voices_valid && voices[v*SW+NOTE_W] &&
                voices[v*SW +: NOTE_W] == NOTE_W'(k))
               load[k] = 1'b1;
   end

   if (HOLD_FRAMES > 0) begin : g_hold
      logic [CW-1:0] cnt_q [NUM_KEYS:1];

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int k = 1; k <= NUM_KEYS; k++) cnt_q[k] <= '0;
         end else begin
            for (int k = 1; k <= NUM_KEYS; k++) begin
               if (load[k])
                  cnt_q[k] <= CW'(HOLD_FRAMES);
               else if (frame_start && cnt_q[k] != '0)
                  cnt_q[k] <= cnt_q[k] - CW'(1);
            end
         end
      end

      always_comb begin
         lit = '0;
         for (int k = 1; k <= NUM_KEYS; k++) lit[k] = (cnt_q[k] != '0);
      end
   end else begin : g_live
      logic [NUM_KEYS:1] live_q;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)          live_q <= '0;
         else if (voices_valid) live_q <= load;
      end

      assign lit = live_q;
   end

   logic              wht1_q, blk1_q, ply1_q, de1_q;
   logic              wht2_q, blk2_q, ply2_q, de2_q;
   logic [NOTE_W-1:0] idx1_q, idx2_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wht1_q <= 1'b0;
         blk1_q <= 1'b0;
         ply1_q <= 1'b0;
         idx1_q <= '0;
         de1_q  <= 1'b0;
         wht2_q <= 1'b0;
         blk2_q <= 1'b0;
         ply2_q <= 1'b0;
         idx2_q <= '0;
         de2_q  <= 1'b0;
      end else begin
         wht1_q <= wht1_d;
         blk1_q <= blk1_d;
         ply1_q <= ply1_d;
         idx1_q <= idx1_d;
         de1_q  <= de;
         wht2_q <= wht1_q;
         blk2_q <= blk1_q;
         ply2_q <= ply1_q;
         idx2_q <= idx1_q;
         de2_q  <= de1_q;
      end
   end

   assign white_key = wht2_q;
   assign black_key = blk2_q;
   assign play      = ply2_q;
   assign key_index = idx2_q;
   assign out_valid = de2_q;

endmodule

// File: tb/tb_piano_key_highlighter.sv
// Bench for piano_key_highlighter: hold-mode and live-only instances checked
// every cycle against a geometric/behavioural model plus literal pins.
module tb_piano_key_highlighter;

   localparam int NV = 8, NK = 64, NW = 7, HF = 4;
   localparam int X0 = 10, WW = 34, BW = 24;
   localparam int YT = 780, YS = 920, YB = 1023;

   logic        clk = 1'b0, reset_n = 1'b0;
   logic [10:0] x = '0;
   logic [9:0]  y = '0;
   logic        de = 1'b0, frame_start = 1'b0, voices_valid = 1'b0;
   logic [NV*(NW+1)-1:0] voices = '0;

   logic          h_w, h_b, h_p, h_ov, l_w, l_b, l_p, l_ov;
   logic [NW-1:0] h_idx, l_idx;

   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   piano_key_highlighter u_h (
      .clk(clk), .reset_n(reset_n), .x(x), .y(y), .de(de),
      .frame_start(frame_start), .voices(voices),
      .voices_valid(voices_valid),
      .white_key(h_w), .black_key(h_b), .play(h_p),
      .key_index(h_idx), .out_valid(h_ov));

   piano_key_highlighter #(.HOLD_FRAMES(0)) u_l (
      .clk(clk), .reset_n(reset_n), .x(x), .y(y), .de(de),
      .frame_start(frame_start), .voices(voices),
      .voices_valid(voices_valid),
      .white_key(l_w), .black_key(l_b), .play(l_p),
      .key_index(l_idx), .out_valid(l_ov));

   typedef struct {
      bit w, b, ph, pl, ov;
      int idx;
   } exp_t;

   exp_t e1 = '{default: 0}, e2 = '{default: 0}, en;
   int   cnt  [0:127];
   bit   live [0:127];
   bit   ld   [0:127];

   // chromatic key number of the w-th natural (A B C D E F G per octave)
   function automatic int wkey(input int w);
      int o;
      case (w % 7)
         0: o = 0;  1: o = 2;  2: o = 3;  3: o = 5;
         4: o = 7;  5: o = 8;  default: o = 10;
      endcase
      return (w / 7) * 12 + o + 1;
   endfunction

   function automatic exp_t geo(input int px, input int py, input bit pde);
      exp_t r;
      r = '{default: 0};
      if (pde && py >= YT && py <= YB) begin
         if (py <= YS)
            for (int wb = 1; wb <= 64; wb++) begin
               int c;
               c = X0 + wb * WW;
               if (!r.b && px > c - BW/2 && px < c + BW/2 &&
                   (wb - 1) % 7 != 1 && (wb - 1) % 7 != 4 &&
                   wkey(wb - 1) + 1 <= NK) begin
                  r.b   = 1;
                  r.idx = wkey(wb - 1) + 1;
               end
            end
         if (!r.b && px > X0) begin
            int d;
            d = px - X0;
            if (d % WW != 0 && wkey(d / WW) <= NK) begin
               r.w   = 1;
               r.idx = wkey(d / WW);
            end
         end
      end
      return r;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e1 = '{default: 0};
         e2 = '{default: 0};
         for (int k = 0; k < 128; k++) begin
            cnt[k]  = 0;
            live[k] = 0;
         end
      end else begin
         en    = geo(int'(x), int'(y), de);
         en.ov = de;
         en.ph = (en.w || en.b) && cnt[en.idx] != 0;
         en.pl = (en.w || en.b) && live[en.idx];
         e2 = e1;
         e1 = en;
         for (int k = 0; k < 128; k++) ld[k] = 0;
         if (voices_valid)
            for (int v = 0; v < NV; v++) begin
               int n;
               n = int'(voices[v*(NW+1) +: NW]);
               if (voices[v*(NW+1)+NW] && n >= 1 && n <= NK) ld[n] = 1;
            end
         for (int k = 1; k <= NK; k++) begin
            if (voices_valid) live[k] = ld[k];
            if (ld[k])                        cnt[k] = HF;
            else if (frame_start && cnt[k] > 0) cnt[k] = cnt[k] - 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("h_white", 32'(h_w), 32'(e2.w));
      chk("h_black", 32'(h_b), 32'(e2.b));
      chk("h_idx",   32'(h_idx), 32'(e2.idx));
      chk("h_play",  32'(h_p), 32'(e2.ph));
      chk("h_valid", 32'(h_ov), 32'(e2.ov));
      chk("l_white", 32'(l_w), 32'(e2.w));
      chk("l_black", 32'(l_b), 32'(e2.b));
      chk("l_idx",   32'(l_idx), 32'(e2.idx));
      chk("l_play",  32'(l_p), 32'(e2.pl));
      chk("l_valid", 32'(l_ov), 32'(e2.ov));
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic setpix(input int px, input int py, input bit d);
      x  = 11'(px);
      y  = 10'(py);
      de = d;
   endtask

   task automatic strobe(input logic [63:0] v, input bit fs);
      voices       = v;
      voices_valid = 1'b1;
      frame_start  = fs;
      tick(1);
      voices_valid = 1'b0;
      frame_start  = 1'b0;
   endtask

   task automatic frame();
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
   endtask

   task automatic pix(input string nm, input int px, input int py,
                      input int ew, input int eb, input int ei);
      setpix(px, py, 1'b1);
      tick(2);
      chk({nm, "_w"}, 32'(h_w), 32'(ew));
      chk({nm, "_b"}, 32'(h_b), 32'(eb));
      chk({nm, "_i"}, 32'(h_idx), 32'(ei));
   endtask

   initial begin
      tick(2);
      chk("rst_valid", 32'(h_ov), 0);
      chk("rst_idx", 32'(h_idx), 0);
      reset_n = 1'b1;
      tick(1);

      setpix(20, 950, 1'b1);
      tick(1);
      chk("lat1_valid", 32'(h_ov), 0);
      chk("lat1_white", 32'(h_w), 0);
      tick(1);
      chk("lat2_valid", 32'(h_ov), 1);
      chk("lat2_white", 32'(h_w), 1);
      chk("lat2_idx", 32'(h_idx), 1);

      pix("x44",   44,   950, 0, 0, 0);
      pix("x60",   60,   950, 1, 0, 3);
      pix("blk40", 40,   800, 0, 1, 2);
      pix("wht30", 30,   800, 1, 0, 1);
      pix("bc78",  78,   800, 0, 0, 0);
      pix("k64",   1300, 800, 1, 0, 64);
      pix("edge",  1302, 800, 0, 0, 0);
      pix("ytop",  20,   779, 0, 0, 0);
      pix("ybot",  20,   1023, 1, 0, 1);
      setpix(20, 950, 1'b0);
      tick(2);
      chk("de0_valid", 32'(h_ov), 0);
      chk("de0_white", 32'(h_w), 0);

      // hold decay on key 5 (C#)
      setpix(112, 800, 1'b1);
      strobe(64'h85, 1'b0);
      tick(3);
      chk("hold_on", 32'(h_p), 1);
      chk("live_on", 32'(l_p), 1);
      for (int i = 1; i <= 5; i++) begin
         frame();
         tick(3);
         chk("hold_decay", 32'(h_p), (i <= 3) ? 1 : 0);
      end
      strobe(64'h85, 1'b0);
      setpix(130, 950, 1'b1);
      tick(3);
      chk("key6_off", 32'(h_p), 0);

      // load beats decrement with counter at 1
      setpix(112, 800, 1'b1);
      repeat (3) frame();
      strobe(64'h85, 1'b1);
      tick(3);
      chk("coll_on", 32'(h_p), 1);
      repeat (3) frame();
      tick(3);
      chk("coll_hold", 32'(h_p), 1);
      frame();
      tick(3);
      chk("coll_off", 32'(h_p), 0);

      // invalid slots
      strobe({40'h0, 8'h07, 8'hC1, 8'h80}, 1'b0);
      setpix(146, 800, 1'b1);
      tick(3);
      chk("inv_k7", 32'(h_p), 0);
      chk("inv_k7_idx", 32'(h_idx), 7);
      setpix(20, 950, 1'b1);
      tick(3);
      chk("inv_k1", 32'(h_p), 0);

      // multiple slots
      strobe({8'hC0, 24'h0, 8'h81, 24'h0}, 1'b0);
      tick(3);
      chk("multi_k1", 32'(h_p), 1);
      setpix(1280, 950, 1'b1);
      tick(3);
      chk("multi_k64", 32'(h_p), 1);
      chk("multi_k64_l", 32'(l_p), 1);

      // live-only on key 9
      setpix(200, 950, 1'b1);
      strobe(64'h89, 1'b0);
      tick(3);
      chk("live9_on", 32'(l_p), 1);
      chk("live9_idx", 32'(l_idx), 9);
      strobe(64'h09, 1'b0);
      tick(3);
      chk("live9_off", 32'(l_p), 0);
      chk("hold9_on", 32'(h_p), 1);

      // asynchronous reset mid-line
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_white", 32'(h_w), 0);
      chk("arst_play", 32'(h_p), 0);
      chk("arst_valid", 32'(h_ov), 0);
      chk("arst_idx", 32'(h_idx), 0);
      chk("arst_lvalid", 32'(l_ov), 0);
      tick(2);
      reset_n = 1'b1;
      tick(4);
      chk("post_rst_play", 32'(h_p), 0);
      chk("post_rst_white", 32'(h_w), 1);

      setpix(0, 0, 1'b0);
      tick(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
